// File: rtl/alu_seq.sv
// Registered 8051-style ALU with a start/done handshake. MUL and DIV iterate one
// bit per clock (shift-add / restoring); every other operation finishes in one cycle.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] op_in_1,
  input  logic [WIDTH-1:0] op_in_2,
  input  logic             carry_in,
  input  logic             aux_carry_in,
  input  logic             bit_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] op_out_1,
  output logic [WIDTH-1:0] op_out_2,
  output logic             carry_out,
  output logic             aux_carry_out,
  output logic             overflow_out,
  output logic [2:0]       flag_we,
  output logic [1:0]       debug_state
);

  // Handshake: a request is taken on a rising edge with start && ready; operands are
  // sampled then and may change afterwards. done pulses for exactly one cycle per
  // accepted request, and results/flags/flag_we hold until the next done.
  localparam logic [OPW-1:0] ALU_ADD  = OPW'(0);
  localparam logic [OPW-1:0] ALU_ADDC = OPW'(1);
  localparam logic [OPW-1:0] ALU_SUBB = OPW'(2);
  localparam logic [OPW-1:0] ALU_INC  = OPW'(3);
  localparam logic [OPW-1:0] ALU_DEC  = OPW'(4);
  localparam logic [OPW-1:0] ALU_MUL  = OPW'(5);
  localparam logic [OPW-1:0] ALU_DIV  = OPW'(6);
  localparam logic [OPW-1:0] ALU_RL   = OPW'(7);
  localparam logic [OPW-1:0] ALU_RLC  = OPW'(8);
  localparam logic [OPW-1:0] ALU_RR   = OPW'(9);
  localparam logic [OPW-1:0] ALU_RRC  = OPW'(10);
  localparam logic [OPW-1:0] ALU_CPL  = OPW'(11);
  localparam logic [OPW-1:0] ALU_SWAP = OPW'(12);
  localparam logic [OPW-1:0] ALU_ANL  = OPW'(13);
  localparam logic [OPW-1:0] ALU_ORL  = OPW'(14);
  localparam logic [OPW-1:0] ALU_XRL  = OPW'(15);
  localparam logic [OPW-1:0] ALU_DA   = OPW'(16);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0]   work_hi, work_lo, b_q;
  logic               div_q;
  logic [CW-1:0]      cnt;

  logic               cin_add;
  logic [WIDTH:0]     add_sum, sub_diff;
  logic [4:0]         add_nib, sub_nib;
  logic [2*WIDTH-1:0] inc_val;
  logic [WIDTH-1:0]   da_out;
  logic               da_carry;
  logic [2:0]         da_we;

  logic [WIDTH-1:0]   sc_o1, sc_o2;
  logic               sc_cy, sc_ac, sc_ov, sc_iter;
  logic [2:0]         sc_we;

  logic [WIDTH-1:0]   it_hi, it_lo, it_b;
  logic               it_div;
  logic [2*WIDTH-1:0] iter_next;

  assign cin_add  = (alu_opcode == ALU_ADDC) & carry_in;
  assign add_sum  = {1'b0, op_in_1} + {1'b0, op_in_2} + {{WIDTH{1'b0}}, cin_add};
  assign add_nib  = {1'b0, op_in_1[3:0]} + {1'b0, op_in_2[3:0]} + {4'b0, cin_add};
  assign sub_diff = {1'b0, op_in_1} - {1'b0, op_in_2} - {{WIDTH{1'b0}}, carry_in};
  assign sub_nib  = {1'b0, op_in_1[3:0]} - {1'b0, op_in_2[3:0]} - {4'b0, carry_in};
  assign inc_val  = {op_in_2, op_in_1} + {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Decimal adjust only has meaning for a BCD byte.
  if (WIDTH == 8) begin : g_da
    logic [8:0] da_lo;
    logic [7:0] da_res;
    logic       da_cy;
    always_comb begin
      da_lo = {1'b0, op_in_1};
      if (aux_carry_in || op_in_1[3:0] > 4'd9) da_lo = da_lo + 9'h006;
      da_res = da_lo[7:0];
      da_cy  = carry_in;
      if (carry_in || da_lo[8] || da_lo[7:4] > 4'd9) begin
        da_res = da_lo[7:0] + 8'h60;
        da_cy  = 1'b1;
      end
    end
    assign da_out   = da_res;
    assign da_carry = da_cy;
    assign da_we    = 3'b100;
  end else begin : g_no_da
    assign da_out   = op_in_1;
    assign da_carry = 1'b0;
    assign da_we    = 3'b000;
  end

  // One shift-add step on {hi,lo}; lo starts as the multiplier.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                   input logic [WIDTH-1:0] lo,
                                                   input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    return {s, lo[WIDTH-1:1]};
  endfunction

  // One restoring-division step on {remainder, dividend/quotient}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] qn;
    r  = {rem, q[WIDTH-1]};
    qn = {q[WIDTH-2:0], 1'b0};
    if (r >= {1'b0, b}) begin
      r     = r - {1'b0, b};
      qn[0] = 1'b1;
    end
    return {r[WIDTH-1:0], qn};
  endfunction

  always_comb begin
    sc_o1   = op_in_1;
    sc_o2   = op_in_2;
    sc_cy   = 1'b0;
    sc_ac   = 1'b0;
    sc_ov   = 1'b0;
    sc_we   = 3'b000;
    sc_iter = 1'b0;
    case (alu_opcode)
      ALU_ADD, ALU_ADDC: begin
        sc_o1 = add_sum[WIDTH-1:0];
        sc_cy = add_sum[WIDTH];
        sc_ac = add_nib[4];
        sc_ov = (op_in_1[WIDTH-1] == op_in_2[WIDTH-1]) && (add_sum[WIDTH-1] != op_in_1[WIDTH-1]);
        sc_we = 3'b111;
      end
      ALU_SUBB: begin
        sc_o1 = sub_diff[WIDTH-1:0];
        sc_cy = sub_diff[WIDTH];
        sc_ac = sub_nib[4];
        sc_ov = (op_in_1[WIDTH-1] != op_in_2[WIDTH-1]) && (sub_diff[WIDTH-1] != op_in_1[WIDTH-1]);
        sc_we = 3'b111;
      end
      ALU_INC:  {sc_o2, sc_o1} = inc_val;
      ALU_DEC:  sc_o1 = op_in_1 - WIDTH'(1);
      ALU_MUL:  sc_iter = 1'b1;
      ALU_DIV: begin
        if (op_in_2 != '0) begin
          sc_iter = 1'b1;
        end else begin
          sc_o1 = '1;
          sc_o2 = op_in_1;
          sc_ov = 1'b1;
          sc_we = 3'b101;
        end
      end
      ALU_RL:   sc_o1 = {op_in_1[WIDTH-2:0], op_in_1[WIDTH-1]};
      ALU_RR:   sc_o1 = {op_in_1[0], op_in_1[WIDTH-1:1]};
      ALU_RLC: begin
        sc_o1 = {op_in_1[WIDTH-2:0], carry_in};
        sc_cy = op_in_1[WIDTH-1];
        sc_we = 3'b100;
      end
      ALU_RRC: begin
        sc_o1 = {carry_in, op_in_1[WIDTH-1:1]};
        sc_cy = op_in_1[0];
        sc_we = 3'b100;
      end
      ALU_CPL:  sc_o1 = ~op_in_1;
      ALU_SWAP: sc_o1 = {op_in_1[WIDTH/2-1:0], op_in_1[WIDTH-1:WIDTH/2]};
      ALU_ANL: begin
        sc_o1 = op_in_1 & op_in_2;
        sc_cy = carry_in & bit_in;
        sc_we = 3'b100;
      end
      ALU_ORL: begin
        sc_o1 = op_in_1 | op_in_2;
        sc_cy = carry_in | bit_in;
        sc_we = 3'b100;
      end
      ALU_XRL:  sc_o1 = op_in_1 ^ op_in_2;
      ALU_DA: begin
        sc_o1 = da_out;
        sc_cy = da_carry;
        sc_we = da_we;
      end
      default: ;
    endcase
  end

  // The first iteration runs on the acceptance edge straight from the inputs.
  always_comb begin
    it_hi     = (state == S_IDLE) ? '0 : work_hi;
    it_lo     = (state == S_IDLE) ? op_in_1 : work_lo;
    it_b      = (state == S_IDLE) ? op_in_2 : b_q;
    it_div    = (state == S_IDLE) ? (alu_opcode == ALU_DIV) : div_q;
    iter_next = it_div ? div_step(it_hi, it_lo, it_b) : mul_step(it_hi, it_lo, it_b);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = sc_iter ? S_ITER : S_EXEC;
      S_EXEC:  state_next = S_IDLE;
      S_ITER:  if (done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = (state == S_IDLE);
    debug_state = state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done          <= 1'b0;
      op_out_1      <= '0;
      op_out_2      <= '0;
      carry_out     <= 1'b0;
      aux_carry_out <= 1'b0;
      overflow_out  <= 1'b0;
      flag_we       <= 3'b000;
      work_hi       <= '0;
      work_lo       <= '0;
      b_q           <= '0;
      div_q         <= 1'b0;
      cnt           <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        if (sc_iter) begin
          {work_hi, work_lo} <= iter_next;
          b_q   <= op_in_2;
          div_q <= (alu_opcode == ALU_DIV);
          cnt   <= CW'(1);
        end else begin
          op_out_1      <= sc_o1;
          op_out_2      <= sc_o2;
          carry_out     <= sc_cy;
          aux_carry_out <= sc_ac;
          overflow_out  <= sc_ov;
          flag_we       <= sc_we;
          done          <= 1'b1;
        end
      end else if (state == S_ITER && !done) begin
        {work_hi, work_lo} <= iter_next;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          // Both algorithms leave {high/remainder, low/quotient} in the same slots.
          op_out_2      <= iter_next[2*WIDTH-1:WIDTH];
          op_out_1      <= iter_next[WIDTH-1:0];
          carry_out     <= 1'b0;
          aux_carry_out <= 1'b0;
          overflow_out  <= div_q ? 1'b0 : (iter_next[2*WIDTH-1:WIDTH] != '0);
          flag_we       <= 3'b101;
          done          <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random operations checked against an
// arithmetic reference model of the 8051 ALU rules.
module tb_alu_seq;
  localparam int W = 8;
  localparam int OP_ADD = 0, OP_ADDC = 1, OP_SUBB = 2, OP_INC = 3, OP_DEC = 4,
                 OP_MUL = 5, OP_DIV = 6, OP_RL = 7, OP_RLC = 8, OP_RR = 9,
                 OP_RRC = 10, OP_CPL = 11, OP_SWAP = 12, OP_ANL = 13, OP_ORL = 14,
                 OP_XRL = 15, OP_DA = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   alu_opcode;
  logic [W-1:0] op_in_1, op_in_2;
  logic         carry_in, aux_carry_in, bit_in;
  logic         ready, done;
  logic [W-1:0] op_out_1, op_out_2;
  logic         carry_out, aux_carry_out, overflow_out;
  logic [2:0]   flag_we;
  logic [1:0]   debug_state;

  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q[$];

  alu_seq #(.WIDTH(W), .OPW(5)) dut (
    .clock(clock), .reset(reset), .start(start), .alu_opcode(alu_opcode),
    .op_in_1(op_in_1), .op_in_2(op_in_2), .carry_in(carry_in),
    .aux_carry_in(aux_carry_in), .bit_in(bit_in), .ready(ready), .done(done),
    .op_out_1(op_out_1), .op_out_2(op_out_2), .carry_out(carry_out),
    .aux_carry_out(aux_carry_out), .overflow_out(overflow_out),
    .flag_we(flag_we), .debug_state(debug_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed expectation: {we[2:0], ov, ac, cy, out2[7:0], out1[7:0]}
  function automatic logic [21:0] ref_model(int op, int a, int b, int c, int ac, int bt);
    int o1, o2, cy, acf, ov, we, r, s, sa, sb, cin, t;
    o1 = a; o2 = b; cy = 0; acf = 0; ov = 0; we = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      OP_ADD, OP_ADDC: begin
        cin = (op == OP_ADDC) ? c : 0;
        r = a + b + cin;
        o1 = r % 256; cy = (r > 255);
        acf = ((a % 16) + (b % 16) + cin) > 15;
        s = sa + sb + cin; ov = (s > 127) || (s < -128);
        we = 7;
      end
      OP_SUBB: begin
        r = a - b - c;
        o1 = (r + 256) % 256; cy = (r < 0);
        acf = ((a % 16) - (b % 16) - c) < 0;
        s = sa - sb - c; ov = (s > 127) || (s < -128);
        we = 7;
      end
      OP_INC: begin
        r = (b * 256 + a + 1) % 65536;
        o1 = r % 256; o2 = r / 256;
      end
      OP_DEC: o1 = (a + 255) % 256;
      OP_MUL: begin
        r = a * b; o1 = r % 256; o2 = r / 256; ov = (o2 != 0); we = 5;
      end
      OP_DIV: begin
        if (b == 0) begin o1 = 255; o2 = a; ov = 1; end
        else begin o1 = a / b; o2 = a % b; end
        we = 5;
      end
      OP_RL:   o1 = (a * 2) % 256 + a / 128;
      OP_RR:   o1 = a / 2 + (a % 2) * 128;
      OP_RLC:  begin o1 = (a * 2) % 256 + c; cy = a / 128; we = 4; end
      OP_RRC:  begin o1 = a / 2 + c * 128; cy = a % 2; we = 4; end
      OP_CPL:  o1 = 255 - a;
      OP_SWAP: o1 = (a % 16) * 16 + a / 16;
      OP_ANL:  begin o1 = a & b; cy = c & bt; we = 4; end
      OP_ORL:  begin o1 = a | b; cy = c | bt; we = 4; end
      OP_XRL:  o1 = a ^ b;
      OP_DA: begin
        t = a;
        if (ac != 0 || (a % 16) > 9) t = t + 6;
        if (c != 0 || t > 255 || ((t % 256) / 16) > 9) begin
          o1 = (t % 256 + 96) % 256; cy = 1;
        end else begin
          o1 = t % 256; cy = c;
        end
        we = 4;
      end
      default: ;
    endcase
    return {3'(we), 1'(ov), 1'(acf), 1'(cy), 8'(o2), 8'(o1)};
  endfunction

  task automatic run_op(input string tag, input int op, input int a, input int b,
                        input int c, input int ac, input int bt, input bit noise);
    logic [21:0] e;
    int lat, k, exp_lat;
    exp_q.push_back(ref_model(op, a, b, c, ac, bt));
    exp_lat = (op == OP_MUL || (op == OP_DIV && b != 0)) ? W : 1;
    k = 0;
    while (!ready && k < 50) begin @(negedge clock); k++; end
    if (k == 50) check({tag, "_ready_timeout"}, ready, 1);
    alu_opcode = 5'(op); op_in_1 = 8'(a); op_in_2 = 8'(b);
    carry_in = 1'(c); aux_carry_in = 1'(ac); bit_in = 1'(bt);
    start = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      start = 1'b0;
      if (done) break;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        alu_opcode = 5'($urandom_range(0, 31));
        op_in_1 = 8'($urandom); op_in_2 = 8'($urandom);
        carry_in = 1'($urandom); aux_carry_in = 1'($urandom);
      end
    end
    e = exp_q.pop_front();
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_out1"}, op_out_1, e[7:0]);
    check({tag, "_out2"}, op_out_2, e[15:8]);
    check({tag, "_flag_we"}, flag_we, e[21:19]);
    if (e[21]) check({tag, "_cy"}, carry_out, e[16]);
    if (e[20]) check({tag, "_ac"}, aux_carry_out, e[17]);
    if (e[19]) check({tag, "_ov"}, overflow_out, e[18]);
    @(negedge clock);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ready_after"}, ready, 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_out1"}, op_out_1, 0);
    check({tag, "_out2"}, op_out_2, 0);
    check({tag, "_flags"}, {carry_out, aux_carry_out, overflow_out}, 0);
    check({tag, "_flag_we"}, flag_we, 0);
  endtask

  initial begin
    int op, a, b, dcount;
    reset = 1'b1; start = 1'b0; alu_opcode = '0; op_in_1 = '0; op_in_2 = '0;
    carry_in = 1'b0; aux_carry_in = 1'b0; bit_in = 1'b0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset = 1'b0;
    @(negedge clock);

    run_op("add_7f_01", OP_ADD, 'h7F, 'h01, 0, 0, 0, 0);
    run_op("subb_10_01", OP_SUBB, 'h10, 'h01, 1, 0, 0, 0);
    run_op("mul_12_34", OP_MUL, 'h12, 'h34, 0, 0, 0, 1);
    run_op("div_fb_12", OP_DIV, 'hFB, 'h12, 0, 0, 0, 1);
    run_op("div_by_0", OP_DIV, 'hFB, 'h00, 0, 0, 0, 0);
    run_op("add_56_67", OP_ADD, 'h56, 'h67, 0, 0, 0, 0);
    run_op("da_bd", OP_DA, 'hBD, 'h00, 0, 0, 0, 0);
    run_op("inc_wrap", OP_INC, 'hFF, 'hFF, 0, 0, 0, 0);
    run_op("dec_wrap", OP_DEC, 'h00, 'h5A, 0, 0, 0, 0);
    run_op("mul_ff_ff", OP_MUL, 'hFF, 'hFF, 0, 0, 0, 0);
    run_op("div_small", OP_DIV, 'h03, 'hFF, 0, 0, 0, 0);
    run_op("unknown", 31, 'hA5, 'h3C, 1, 1, 1, 0);

    // Reset during the fourth cycle of a MUL: abort, no done.
    alu_opcode = 5'(OP_MUL); op_in_1 = 8'h12; op_in_2 = 8'h34; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_cleared("reset_mid_mul");
    @(negedge clock); reset = 1'b0;
    dcount = 0;
    repeat (12) begin @(negedge clock); if (done) dcount++; end
    check("reset_mid_mul_no_done", dcount, 0);
    run_op("add_after_reset", OP_ADD, 'h7F, 'h01, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 20);
      if ($urandom_range(0, 9) == 0) op = $urandom_range(17, 31);
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
